// File: rtl/mole_game_ctrl_pkg.sv
// Shared definitions for the whack-a-mole controller: state encoding, widths and
// the helper that picks the next mole hole.
package mole_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHOW     = 2'd1,
    ST_FEEDBACK = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam int NUM_HOLES = 8;
  localparam int POS_W     = 3;
  localparam int BCD_W     = 4;

  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bumping a repeated candidate by one keeps consecutive moles in different holes.
  function automatic logic [POS_W-1:0] next_pos(input logic [POS_W-1:0] cand,
                                                input logic [POS_W-1:0] cur);
    return (cand == cur) ? cand + 3'd1 : cand;
  endfunction

endpackage

// File: rtl/mole_game_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the mole position source.
module mole_game_ctrl_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       master_clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] state
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = {state_q[6:0], state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3]};
    end
  end

  always_ff @(posedge master_clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: places moles, judges whacks and keeps a saturating
// two-digit BCD score; every output is a flop feeding the VGA display directly.
module mole_game_ctrl
  import mole_game_ctrl_pkg::*;
#(
  parameter int         MOLE_CYCLES     = 100_000_000,
  parameter int         FEEDBACK_CYCLES = 50_000_000,
  parameter int         GAME_ROUNDS     = 20,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input  logic             master_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       whack,
  output logic [POS_W-1:0] mole_position,
  output logic             mole_active,
  output logic             guess_correct,
  output logic             guess_wrong,
  output logic [BCD_W-1:0] digit_1,
  output logic [BCD_W-1:0] digit_2,
  output logic             game_over
);

  localparam int MAX_CYC = max_cycles(MOLE_CYCLES, FEEDBACK_CYCLES);
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TIMER_W-1:0] MOLE_LAST = TIMER_W'(MOLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FB_LAST   = TIMER_W'(FEEDBACK_CYCLES - 1);
  localparam logic [7:0]         ROUND_END = 8'(GAME_ROUNDS);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]         round_q, round_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [BCD_W-1:0]   tens_q, tens_d;
  logic [BCD_W-1:0]   ones_q, ones_d;
  logic               active_q, active_d;
  logic               correct_q, correct_d;
  logic               wrong_q, wrong_d;
  logic               over_q, over_d;

  logic [7:0]       lfsr_state;
  logic [7:POS_W]   lfsr_unused;
  logic [POS_W-1:0] cand_pos;
  logic [7:0]       hit_mask;

  mole_game_ctrl_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .master_clk (master_clk),
    .rst        (rst),
    .en         (1'b1),
    .state      (lfsr_state)
  );

  assign cand_pos    = lfsr_state[POS_W-1:0];
  assign lfsr_unused = lfsr_state[7:POS_W];
  assign hit_mask    = 8'd1 << pos_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    round_d   = round_q;
    pos_d     = pos_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SHOW;
          timer_d = '0;
          round_d = '0;
          tens_d  = '0;
          ones_d  = '0;
          pos_d   = next_pos(cand_pos, pos_q);
        end
      end
      ST_SHOW: begin
        timer_d = timer_q + 1'b1;
        // A whack on the final mole cycle still counts, so it is checked before the timeout.
        if (whack != 8'd0) begin
          state_d   = ST_FEEDBACK;
          timer_d   = '0;
          correct_d = (whack == hit_mask);
          wrong_d   = (whack != hit_mask);
          if (whack == hit_mask) begin
            if (ones_q != 4'd9) begin
              ones_d = ones_q + 4'd1;
            end else if (tens_q != 4'd9) begin
              ones_d = '0;
              tens_d = tens_q + 4'd1;
            end
          end
        end else if (timer_q == MOLE_LAST) begin
          state_d = ST_FEEDBACK;
          timer_d = '0;
          wrong_d = 1'b1;
        end
      end
      ST_FEEDBACK: begin
        timer_d   = timer_q + 1'b1;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        if (timer_q == FB_LAST) begin
          timer_d   = '0;
          round_d   = round_q + 8'd1;
          correct_d = 1'b0;
          wrong_d   = 1'b0;
          if (round_q + 8'd1 == ROUND_END) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHOW;
            pos_d   = next_pos(cand_pos, pos_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d == ST_SHOW);
    over_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge master_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      round_q   <= '0;
      pos_q     <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      active_q  <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      round_q   <= round_d;
      pos_q     <= pos_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      active_q  <= active_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      over_q    <= over_d;
    end
  end

  assign mole_position = pos_q;
  assign mole_active   = active_q;
  assign guess_correct = correct_q;
  assign guess_wrong   = wrong_q;
  assign digit_1       = tens_q;
  assign digit_2       = ones_q;
  assign game_over     = over_q;

endmodule
